// File: rtl/gesture_pkg.sv
// Shared types for the gesture pipeline: coordinate width, frame sequencer
// states and the palm geometry record passed from the palm finder downstream.
package gesture_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARMED,
        ACTIVE,
        SETTLE,
        CAPTURE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] sr;
        logic [COORD_W-1:0] sc;
        logic [COORD_W-1:0] er;
        logic [COORD_W-1:0] ec;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } palm_res_t;

endpackage

// File: rtl/palm_res_reg.sv
// Palm result holding register: latches one frame's geometry, presents it
// with valid/ready, and counts frames lost because the previous result was
// still waiting for the consumer.
module palm_res_reg
    import gesture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_capture,
    input  palm_res_t  i_res,
    input  logic       i_found,
    input  logic       i_size_err,
    input  logic       i_ready,
    output logic       o_valid,
    output palm_res_t  o_res,
    output logic       o_found,
    output logic       o_size_err,
    output logic [7:0] o_drop_cnt
);

    logic       r_valid;
    palm_res_t  r_res;
    logic       r_found;
    logic       r_size_err;
    logic [7:0] r_drop_cnt;

    // A capture while an unacknowledged result is held is dropped; a
    // same-cycle ack frees the slot so the new result is taken instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_res      <= '0;
            r_found    <= 1'b0;
            r_size_err <= 1'b0;
            r_drop_cnt <= '0;
        end else if (i_capture && r_valid && !i_ready) begin
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (i_capture) begin
            r_res      <= i_res;
            r_found    <= i_found;
            r_size_err <= i_size_err;
            r_valid    <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_res      = r_res;
    assign o_found    = r_found;
    assign o_size_err = r_size_err;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/palm_frame_ctrl.sv
// Frame-level sequencer for palm identification: clears the palm finder
// before each frame, gates its pixel strobe to exactly one frame, then
// captures the palm geometry and hands it downstream.
module palm_frame_ctrl
    import gesture_pkg::state_t;
    import gesture_pkg::palm_res_t;
    import gesture_pkg::COORD_W;
#(
    parameter int unsigned IMG_W      = 120,
    parameter int unsigned IMG_H      = 160,
    parameter int unsigned CLR_CYCLES = 4,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned MIN_WIDTH  = 18
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               vsync_i,
    input  logic               de_i,
    output logic               pid_rst,
    output logic               pid_de,
    input  logic [COORD_W-1:0] pid_sr,
    input  logic [COORD_W-1:0] pid_sc,
    input  logic [COORD_W-1:0] pid_er,
    input  logic [COORD_W-1:0] pid_ec,
    input  logic [COORD_W-1:0] pid_w,
    input  logic [COORD_W-1:0] pid_h,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] res_sr,
    output logic [COORD_W-1:0] res_sc,
    output logic [COORD_W-1:0] res_er,
    output logic [COORD_W-1:0] res_ec,
    output logic [COORD_W-1:0] res_w,
    output logic [COORD_W-1:0] res_h,
    output logic               res_found,
    output logic               res_size_err,
    output logic [7:0]         drop_cnt,
    output logic               busy
);

    localparam logic [14:0] FRAME_PIX = 15'(IMG_W * IMG_H);

    state_t      r_state;
    state_t      w_next;
    logic        r_vs_q;
    logic        w_vs_rise;
    logic [3:0]  r_cnt;
    logic [14:0] r_pix;
    logic        r_pend;
    logic        w_pid_rst;
    logic        w_pid_de;
    logic        w_count;
    logic        w_capture;
    logic        w_found;
    logic        w_size_err;
    palm_res_t   w_pid_res;
    palm_res_t   w_res;

    assign w_vs_rise = vsync_i & ~r_vs_q;

    // Next-state and per-state strobes; the frame is cut off on the pixel
    // that reaches FRAME_PIX so overflow pixels are never forwarded.
    always_comb begin
        w_next    = r_state;
        w_pid_rst = 1'b0;
        w_pid_de  = 1'b0;
        w_count   = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            gesture_pkg::IDLE: begin
                w_pid_rst = 1'b1;
                if (w_vs_rise && enable) w_next = gesture_pkg::CLEAR;
            end
            gesture_pkg::CLEAR: begin
                w_pid_rst = 1'b1;
                if (r_cnt == 4'(CLR_CYCLES - 1)) w_next = gesture_pkg::ARMED;
            end
            gesture_pkg::ARMED: begin
                if (de_i) begin
                    w_pid_de = 1'b1;
                    w_count  = 1'b1;
                    w_next   = gesture_pkg::ACTIVE;
                end
            end
            gesture_pkg::ACTIVE: begin
                w_pid_de = de_i;
                w_count  = de_i;
                if (w_vs_rise || (de_i && r_pix == FRAME_PIX - 15'd1))
                    w_next = gesture_pkg::SETTLE;
            end
            gesture_pkg::SETTLE: begin
                if (r_cnt == 4'(SETTLE - 1)) w_next = gesture_pkg::CAPTURE;
            end
            gesture_pkg::CAPTURE: begin
                w_capture = 1'b1;
                w_next    = (r_pend && enable) ? gesture_pkg::CLEAR : gesture_pkg::IDLE;
            end
            default: w_next = gesture_pkg::IDLE;
        endcase
    end

    // State register, dwell counter, pixel counter and short-frame restart flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= gesture_pkg::IDLE;
            r_vs_q  <= 1'b0;
            r_cnt   <= '0;
            r_pix   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vs_q  <= vsync_i;
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
            if (w_next == gesture_pkg::CLEAR) begin
                r_pix <= '0;
            end else if (w_count) begin
                r_pix <= r_pix + 15'd1;
            end
            if (r_state == gesture_pkg::ACTIVE && w_vs_rise) begin
                r_pend <= 1'b1;
            end else if (r_state == gesture_pkg::CAPTURE) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign w_pid_res  = '{sr: pid_sr, sc: pid_sc, er: pid_er, ec: pid_ec, w: pid_w, h: pid_h};
    assign w_found    = (pid_w >= COORD_W'(MIN_WIDTH));
    assign w_size_err = (r_pix != FRAME_PIX);

    palm_res_reg u_res (
        .clk        (clk),
        .rst        (rst),
        .i_capture  (w_capture),
        .i_res      (w_pid_res),
        .i_found    (w_found),
        .i_size_err (w_size_err),
        .i_ready    (res_ready),
        .o_valid    (res_valid),
        .o_res      (w_res),
        .o_found    (res_found),
        .o_size_err (res_size_err),
        .o_drop_cnt (drop_cnt)
    );

    assign pid_rst = w_pid_rst;
    assign pid_de  = w_pid_de;
    assign busy    = (r_state != gesture_pkg::IDLE);
    assign res_sr  = w_res.sr;
    assign res_sc  = w_res.sc;
    assign res_er  = w_res.er;
    assign res_ec  = w_res.ec;
    assign res_w   = w_res.w;
    assign res_h   = w_res.h;

endmodule

// File: tb/tb_palm_frame_ctrl.sv
// Directed bench for palm_frame_ctrl: full, overflowing, short and narrow
// frames, back-pressure with drops, and reset with a pending result.
module tb_palm_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst, enable, vsync_i, de_i, res_ready;
    logic       pid_rst, pid_de, res_valid, res_found, res_size_err, busy;
    logic [9:0] pid_sr, pid_sc, pid_er, pid_ec, pid_w, pid_h;
    logic [9:0] res_sr, res_sc, res_er, res_ec, res_w, res_h;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // negedge monitor: forwarded pixels, valid cycles, snapshot of held result
    int         fwd_cnt = 0;
    int         vld_cyc = 0;
    logic [9:0] m_sc = '0, m_ec = '0;
    logic       m_found = 1'b0, m_err = 1'b0;

    int fwd0, vld0;

    always #5 clk = ~clk;

    palm_frame_ctrl #(
        .IMG_W(120), .IMG_H(160), .CLR_CYCLES(4), .SETTLE(2), .MIN_WIDTH(18)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .vsync_i(vsync_i), .de_i(de_i),
        .pid_rst(pid_rst), .pid_de(pid_de),
        .pid_sr(pid_sr), .pid_sc(pid_sc), .pid_er(pid_er), .pid_ec(pid_ec),
        .pid_w(pid_w), .pid_h(pid_h),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sr(res_sr), .res_sc(res_sc), .res_er(res_er), .res_ec(res_ec),
        .res_w(res_w), .res_h(res_h),
        .res_found(res_found), .res_size_err(res_size_err),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    always @(negedge clk) begin
        if (pid_de) fwd_cnt++;
        if (res_valid) begin
            vld_cyc++;
            m_sc    = res_sc;
            m_ec    = res_ec;
            m_found = res_found;
            m_err   = res_size_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_palm(input int sr, input int sc, input int er, input int ec,
                            input int w, input int h);
        pid_sr = 10'(sr); pid_sc = 10'(sc); pid_er = 10'(er);
        pid_ec = 10'(ec); pid_w  = 10'(w);  pid_h  = 10'(h);
    endtask

    // vsync pulse, then measure how long pid_rst stays high before ARMED
    task automatic start_frame(input string tag);
        int n;
        vsync_i = 1'b1;
        tick();
        vsync_i = 1'b0;
        n = 0;
        while (pid_rst && n < 50) begin
            n++;
            tick();
        end
        check({tag, "_clr_len"}, 32'(n), 32'd4);
    endtask

    // auto-restarted frame: wait for pid_rst to rise, then measure its length
    task automatic wait_clear_run(input string tag);
        int n, m;
        n = 0;
        while (!pid_rst && n < 30) begin
            n++;
            tick();
        end
        m = 0;
        while (pid_rst && m < 50) begin
            m++;
            tick();
        end
        check({tag, "_auto_clr_len"}, 32'(m), 32'd4);
    endtask

    task automatic drive_de(input int k);
        de_i = 1'b1;
        repeat (k) tick();
        de_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; vsync_i = 1'b0; de_i = 1'b1; res_ready = 1'b0;
        set_palm(0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // reset state, strobe gated even with de_i high
        check("rst_pid_rst", 32'(pid_rst), 32'd1);
        check("rst_pid_de", 32'(pid_de), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_sc", 32'(res_sc), 32'd0);

        rst = 1'b0; de_i = 1'b0;
        tick();

        // vsync while disabled does not start a frame
        vsync_i = 1'b1; tick(); vsync_i = 1'b0;
        repeat (3) tick();
        check("dis_busy", 32'(busy), 32'd0);
        repeat (3) tick();

        // frame A: 19300 pixels, palm cols 40..70, consumer always ready
        enable = 1'b1; res_ready = 1'b1;
        set_palm(10, 40, 10, 70, 31, 1);
        fwd0 = fwd_cnt; vld0 = vld_cyc;
        start_frame("A");
        check("A_busy", 32'(busy), 32'd1);
        drive_de(19300);
        repeat (10) tick();
        check("A_fwd", 32'(fwd_cnt - fwd0), 32'd19200);
        check("A_vld_cyc", 32'(vld_cyc - vld0), 32'd1);
        check("A_sc", 32'(m_sc), 32'd40);
        check("A_ec", 32'(m_ec), 32'd70);
        check("A_found", 32'(m_found), 32'd1);
        check("A_size_err", 32'(m_err), 32'd0);
        check("A_valid_after", 32'(res_valid), 32'd0);
        check("A_idle", 32'(busy), 32'd0);

        // frame B: short frame of 1000 pixels ended by vsync, auto restart
        set_palm(20, 30, 25, 60, 31, 6);
        fwd0 = fwd_cnt; vld0 = vld_cyc;
        start_frame("B");
        drive_de(1000);
        vsync_i = 1'b1; tick(); vsync_i = 1'b0;
        wait_clear_run("B");
        check("B_fwd", 32'(fwd_cnt - fwd0), 32'd1000);
        check("B_vld_cyc", 32'(vld_cyc - vld0), 32'd1);
        check("B_size_err", 32'(m_err), 32'd1);
        check("B_sc", 32'(m_sc), 32'd30);
        check("C_armed_busy", 32'(busy), 32'd1);

        // frame C (auto started): narrow blob width 10, consumer stalled
        res_ready = 1'b0;
        set_palm(50, 60, 80, 69, 10, 31);
        drive_de(19200);
        repeat (10) tick();
        check("C_valid", 32'(res_valid), 32'd1);
        check("C_w", 32'(res_w), 32'd10);
        check("C_found", 32'(res_found), 32'd0);
        check("C_size_err", 32'(res_size_err), 32'd0);
        check("C_sc", 32'(res_sc), 32'd60);
        check("C_drop", 32'(drop_cnt), 32'd0);

        // frames D, E: still stalled, both dropped, C result held
        set_palm(1, 2, 3, 4, 99, 5);
        start_frame("D");
        drive_de(19200);
        repeat (10) tick();
        check("D_drop", 32'(drop_cnt), 32'd1);
        start_frame("E");
        drive_de(19200);
        repeat (10) tick();
        check("E_drop", 32'(drop_cnt), 32'd2);
        check("E_hold_w", 32'(res_w), 32'd10);
        check("E_hold_sc", 32'(res_sc), 32'd60);
        check("E_valid", 32'(res_valid), 32'd1);

        // single ready pulse clears the held result
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("ack_valid", 32'(res_valid), 32'd0);
        repeat (3) tick();
        check("ack_valid_stays", 32'(res_valid), 32'd0);
        check("ack_drop_kept", 32'(drop_cnt), 32'd2);

        // frame F: short frame leaves a pending result, next frame auto starts
        set_palm(7, 8, 9, 10, 20, 3);
        start_frame("F");
        drive_de(50);
        vsync_i = 1'b1; tick(); vsync_i = 1'b0;
        wait_clear_run("F");
        de_i = 1'b1;
        repeat (5) tick();
        check("G_busy", 32'(busy), 32'd1);
        check("G_pid_de", 32'(pid_de), 32'd1);
        check("F_valid", 32'(res_valid), 32'd1);
        check("F_w", 32'(res_w), 32'd20);

        // reset in ACTIVE with a pending result
        rst = 1'b1;
        tick();
        check("rst2_valid", 32'(res_valid), 32'd0);
        check("rst2_pid_rst", 32'(pid_rst), 32'd1);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_drop", 32'(drop_cnt), 32'd0);
        check("rst2_pid_de", 32'(pid_de), 32'd0);
        rst = 1'b0; de_i = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
